// File: rtl/sico_stream_tap.sv
// sico_stream_tap: passive multi-lane valid/ready tap feeding the SiCo recorder.
// Every accepted beat is timestamped and buffered in a per-lane FIFO. One beat
// per cycle is drained round-robin into a packed record on rec_o:
//   rec_o = {valid, lane_id, drop_flag, ts, data}
// An all-zero rec_o means "no record this cycle".
// The observed streams are never back-pressured. Beats that find their lane
// FIFO full are counted in drop_cnt_o and flagged on the next stored beat of
// that lane.
// Optional build macro SICO_TAP_STALL_CNT_EN adds per-lane stall counters on
// stall_cnt_o.
module sico_stream_tap #(
  parameter  int LANES  = 2,
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  parameter  int TS_W   = 16,
  localparam int LID_W  = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int REC_W  = 1 + LID_W + 1 + TS_W + DATA_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [LANES-1:0]          valid_i,
  input  logic [LANES-1:0]          ready_i,
  input  logic [LANES*DATA_W-1:0]   data_i,
  output logic [REC_W-1:0]          rec_o,
  output logic [31:0]               drop_cnt_o
`ifdef SICO_TAP_STALL_CNT_EN
  ,
  output logic [LANES*32-1:0]       stall_cnt_o
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = 1 + TS_W + DATA_W;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // FIFO storage and state
  logic [ENT_W-1:0] mem_q    [LANES][DEPTH];
  logic [AW:0]      wr_ptr_q [LANES];
  logic [AW:0]      rd_ptr_q [LANES];
  logic [LANES-1:0] pend_q;
  logic [TS_W-1:0]  ts_q,   ts_d;
  logic [LID_W-1:0] last_q, last_d;
  logic [REC_W-1:0] rec_q,  rec_d;
  logic [31:0]      drop_q, drop_d;

  // Per-cycle decode
  logic [LANES-1:0] empty_s;
  logic [LANES-1:0] full_s;
  logic [LANES-1:0] acc_s;
  logic [LANES-1:0] push_s;
  logic [LANES-1:0] drop_s;
  logic [LANES-1:0] pop_s;
  logic [LID_W-1:0] cand_s;
  logic [LID_W-1:0] gnt_s;
  logic             gnt_vld_s;
  logic [ENT_W-1:0] head_s;
  logic [32:0]      drop_sum_s;

  // FIFO occupancy: equal pointers mean empty, differing only in the wrap bit means full
  always_comb begin
    empty_s = '0;
    full_s  = '0;
    for (int n = 0; n < LANES; n++) begin
      empty_s[n] = (wr_ptr_q[n] == rd_ptr_q[n]);
      full_s[n]  = (wr_ptr_q[n][AW] != rd_ptr_q[n][AW]) &&
                   (wr_ptr_q[n][AW-1:0] == rd_ptr_q[n][AW-1:0]);
    end
  end

  // Round-robin grant: first non-empty lane after the last granted one
  always_comb begin
    cand_s    = '0;
    gnt_s     = '0;
    gnt_vld_s = 1'b0;
    pop_s     = '0;
    for (int i = 1; i <= LANES; i++) begin
      cand_s = LID_W'((int'(last_q) + i) % LANES);
      if (!gnt_vld_s && !empty_s[cand_s]) begin
        gnt_vld_s = 1'b1;
        gnt_s     = cand_s;
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
    if (gnt_vld_s) begin
      pop_s[gnt_s] = 1'b1;
    end else begin
      pop_s = '0;
    end
  end

  // Acceptance: a full lane still takes the beat if it is being popped this cycle
  always_comb begin
    acc_s  = valid_i & ready_i;
    push_s = '0;
    drop_s = '0;
    for (int n = 0; n < LANES; n++) begin
      push_s[n] = acc_s[n] & (~full_s[n] | pop_s[n]);
      drop_s[n] = acc_s[n] & full_s[n] & ~pop_s[n];
    end
  end

  // Next-state for timestamp, drop counter, grant pointer and output record
  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    drop_sum_s = {1'b0, drop_q} + 33'($countones(drop_s));
    if (drop_sum_s[32]) begin
      drop_d = 32'hFFFF_FFFF;
    end else begin
      drop_d = drop_sum_s[31:0];
    end
    head_s = mem_q[gnt_s][rd_ptr_q[gnt_s][AW-1:0]];
    if (gnt_vld_s) begin
      last_d = gnt_s;
      rec_d  = {1'b1, gnt_s, head_s};
    end else begin
      last_d = last_q;
      rec_d  = '0;
    end
  end

  // FIFO payload storage; contents are only read when the pointers say valid
  always_ff @(posedge clk_i) begin
    for (int n = 0; n < LANES; n++) begin
      if (push_s[n]) begin
        mem_q[n][wr_ptr_q[n][AW-1:0]] <= {pend_q[n], ts_q, data_i[n*DATA_W +: DATA_W]};
      end
    end
  end

  // Control state: pointers, pending-drop flags, timestamp, counters, record
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int n = 0; n < LANES; n++) begin
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
      end
      pend_q <= '0;
      ts_q   <= '0;
      last_q <= LID_W'(LANES - 1);
      rec_q  <= '0;
      drop_q <= 32'd0;
    end else begin
      for (int n = 0; n < LANES; n++) begin
        if (push_s[n]) begin
          wr_ptr_q[n] <= wr_ptr_q[n] + PTR_ONE;
          pend_q[n]   <= 1'b0;
        end else if (drop_s[n]) begin
          pend_q[n]   <= 1'b1;
        end
        if (pop_s[n]) begin
          rd_ptr_q[n] <= rd_ptr_q[n] + PTR_ONE;
        end
      end
      ts_q   <= ts_d;
      last_q <= last_d;
      rec_q  <= rec_d;
      drop_q <= drop_d;
    end
  end

  assign rec_o      = rec_q;
  assign drop_cnt_o = drop_q;

`ifdef SICO_TAP_STALL_CNT_EN
  for (genvar g = 0; g < LANES; g++) begin : g_stall
    logic [31:0] stall_q;

    // Count cycles where the lane offers data but the sink is not ready
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stall_q <= 32'd0;
      end else if (valid_i[g] && !ready_i[g] && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end

    assign stall_cnt_o[g*32 +: 32] = stall_q;
  end
`endif

endmodule

// File: tb/tb_sico_stream_tap.sv
// Self-checking bench for sico_stream_tap: directed cases from the test plan
// plus a random phase, all compared every cycle against a queue-style model.
module tb_sico_stream_tap;

  localparam int LANES  = 2;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int TS_W   = 16;
  localparam int LID_W  = 1;
  localparam int REC_W  = 1 + LID_W + 1 + TS_W + DATA_W;
  localparam int ENT_W  = 1 + TS_W + DATA_W;

  logic                    clk;
  logic                    rst_n;
  logic [LANES-1:0]        valid;
  logic [LANES-1:0]        ready;
  logic [LANES*DATA_W-1:0] data;
  logic [REC_W-1:0]        rec_o;
  logic [31:0]             drop_cnt_o;
`ifdef SICO_TAP_STALL_CNT_EN
  logic [LANES*32-1:0]     stall_cnt_o;
`endif

  sico_stream_tap #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .valid_i    (valid),
    .ready_i    (ready),
    .data_i     (data),
    .rec_o      (rec_o),
    .drop_cnt_o (drop_cnt_o)
`ifdef SICO_TAP_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: per-lane circular buffers tracked by head index and count
  logic [ENT_W-1:0] m_buf  [LANES][DEPTH];
  int               m_head [LANES];
  int               m_cnt  [LANES];
  bit               m_pend [LANES];
  int               m_last;
  longint           m_drops;
  int               m_ts;
  logic [REC_W-1:0] m_rec;

  // Lane-1 ordering observer used during the overflow case
  bit ovf_mode = 1'b0;
  int prev_l1  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int l = 0; l < LANES; l++) begin
      m_head[l] = 0;
      m_cnt[l]  = 0;
      m_pend[l] = 1'b0;
    end
    m_last  = LANES - 1;
    m_drops = 0;
    m_ts    = 0;
    m_rec   = '0;
  endfunction

  function automatic void model_step();
    bit found;
    int l;
    logic [ENT_W-1:0] ent;
    found = 1'b0;
    m_rec = '0;
    for (int i = 1; i <= LANES; i++) begin
      l = (m_last + i) % LANES;
      if (!found && m_cnt[l] > 0) begin
        found     = 1'b1;
        ent       = m_buf[l][m_head[l]];
        m_head[l] = (m_head[l] + 1) % DEPTH;
        m_cnt[l]  = m_cnt[l] - 1;
        m_last    = l;
        m_rec     = {1'b1, LID_W'(l), ent};
      end
    end
    for (int k = 0; k < LANES; k++) begin
      if (valid[k] && ready[k]) begin
        if (m_cnt[k] < DEPTH) begin
          m_buf[k][(m_head[k] + m_cnt[k]) % DEPTH] =
            {m_pend[k], TS_W'(m_ts), data[k*DATA_W +: DATA_W]};
          m_cnt[k]  = m_cnt[k] + 1;
          m_pend[k] = 1'b0;
        end else begin
          m_pend[k] = 1'b1;
          if (m_drops < 64'h0000_0000_FFFF_FFFF) m_drops = m_drops + 1;
        end
      end
    end
    m_ts = (m_ts + 1) % (1 << TS_W);
  endfunction

  // One clock: drive inputs, let the edge happen, advance model, compare outputs
  task automatic cycle(input logic [LANES-1:0] v, input logic [LANES-1:0] r,
                       input logic [LANES*DATA_W-1:0] d);
    int dv;
    valid = v;
    ready = r;
    data  = d;
    @(posedge clk);
    #1;
    model_step();
    check("rec", 64'(rec_o), 64'(m_rec));
    check("drop_cnt", 64'(drop_cnt_o), 64'(m_drops));
    if (ovf_mode && rec_o[REC_W-1] && rec_o[REC_W-2]) begin
      dv = int'(rec_o[DATA_W-1:0]);
      check("l1_order", 64'(dv > prev_l1), 64'd1);
      check("l1_flag", 64'(rec_o[TS_W+DATA_W]), 64'(dv != prev_l1 + 1));
      prev_l1 = dv;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, LANES*DATA_W'($urandom));
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next edge
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    valid = '0;
    ready = '0;
    #1;
    check("rst_rec", 64'(rec_o), 64'd0);
    check("rst_drop", 64'(drop_cnt_o), 64'd0);
`ifdef SICO_TAP_STALL_CNT_EN
    check("rst_stall", 64'(stall_cnt_o), 64'd0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_rec", 64'(rec_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    valid = '0;
    ready = '0;
    data  = '0;
    model_reset();
    #12;
    check("init_rec", 64'(rec_o), 64'd0);
    check("init_drop", 64'(drop_cnt_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat on lane 0 in cycle 10
    idle(10);
    cycle(2'b01, 2'b01, 16'h005A);
    check("single_c11", 64'(rec_o), 64'd0);
    idle(1);
    check("single_c12", 64'(rec_o), 64'h4000A5A);
    idle(1);
    check("single_c13", 64'(rec_o), 64'd0);

    // Contention in cycle 5
    do_reset();
    idle(5);
    cycle(2'b11, 2'b11, 16'h2211);
    idle(1);
    check("cont_c7", 64'(rec_o), 64'h4000511);
    idle(1);
    check("cont_c8", 64'(rec_o), 64'h6000522);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(LANES'($urandom), LANES'($urandom), LANES*DATA_W'($urandom));
    end
    idle(10);

    // Overflow: lane 1 incrementing data, both lanes accepting every cycle
    do_reset();
    ovf_mode = 1'b1;
    prev_l1  = 0;
    cycle(2'b10, 2'b10, {8'h01, 8'($urandom)});
    cycle(2'b10, 2'b10, {8'h02, 8'($urandom)});
    for (int k = 0; k < 12; k++) begin
      cycle(2'b11, 2'b11, {8'(3 + k), 8'($urandom)});
    end
    check("ovf_drops_nonzero", 64'(drop_cnt_o != 32'd0), 64'd1);
    ovf_mode = 1'b0;

    // Reset mid-stream with beats still buffered and drop flags pending
    for (int k = 0; k < 3; k++) cycle(2'b11, 2'b11, LANES*DATA_W'($urandom));
    do_reset();
    idle(3);
    cycle(2'b01, 2'b01, 16'h0077);
    idle(1);
    check("post_rst_c5", 64'(rec_o), 64'h4000377);
    idle(2);

`ifdef SICO_TAP_STALL_CNT_EN
    // Stall counting on lane 1
    do_reset();
    for (int k = 0; k < 7; k++) cycle(2'b10, 2'b00, LANES*DATA_W'($urandom));
    cycle(2'b10, 2'b10, LANES*DATA_W'($urandom));
    check("stall_l1", 64'(stall_cnt_o[63:32]), 64'd7);
    check("stall_l0", 64'(stall_cnt_o[31:0]), 64'd0);
    idle(3);
`endif

    // Timestamp wrap: lane 0 beats in cycles 65535 and 65536
    do_reset();
    idle(65535);
    cycle(2'b01, 2'b01, 16'h00A1);
    cycle(2'b01, 2'b01, 16'h00A2);
    check("wrap_rec_ffff", 64'(rec_o), 64'h4FFFFA1);
    idle(1);
    check("wrap_rec_0000", 64'(rec_o), 64'h40000A2);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
